demux_filtro: RTL and testbench

//   Input-side counterpart of the band output mux: routes one signed sample stream to the
//   low/mid/high recursive band filters. Switches band only on a sample boundary. After

---
 rtl/filtro_pkg.sv | 32 +++
 rtl/demux_filtro_mute_counter.sv | 36 +++
 rtl/demux_filtro.sv | 132 +++++++++++++
 tb/tb_demux_filtro.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared constants for the band demux and the band output mux:
// band codes, FSM state encoding and default sample width.
package filtro_pkg;

  localparam int WIDTH_DEF = 22;

  localparam logic [1:0] BANDA_NINGUNA = 2'b00;
  localparam logic [1:0] BANDA_BAJA    = 2'b01;
  localparam logic [1:0] BANDA_MEDIA   = 2'b10;
  localparam logic [1:0] BANDA_ALTA    = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MUTE = 1'b1
  } estado_t;

  // Lane mask {alta, media, baja} for a band code.
  function automatic logic [2:0] banda_onehot(
    input logic [1:0] b
  );
    logic [2:0] m;
    m = 3'b000;
    unique case (b)
      BANDA_BAJA:  m = 3'b001;
      BANDA_MEDIA: m = 3'b010;
      BANDA_ALTA:  m = 3'b100;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/demux_filtro_mute_counter.sv
// Down-counter of zero samples still owed to a newly selected band.
// Ports: clk, reset, load/load_value, dec -> count, zero.
module mute_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       dec,
  output logic [7:0] count,
  output logic       zero
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 8'd0);

endmodule

// File: rtl/demux_filtro.sv
// Routes one signed sample stream to the low/mid/high band filters,
// injecting MUTE_SAMPLES zeros into a band right after it is selected.
// Ports: clk, reset, muestra_in/muestra_valid/sel in;
//        banda_*/valid_* per band, sel_activo, cambio_banda out.
module demux_filtro
  import filtro_pkg::*;
#(
  parameter int width        = WIDTH_DEF,
  parameter int MUTE_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [width-1:0] muestra_in,
  input  logic                    muestra_valid,
  input  logic [1:0]              sel,
  output logic signed [width-1:0] banda_baja,
  output logic signed [width-1:0] banda_media,
  output logic signed [width-1:0] banda_alta,
  output logic                    valid_baja,
  output logic                    valid_media,
  output logic                    valid_alta,
  output logic [1:0]              sel_activo,
  output logic                    cambio_banda
);

  localparam logic [7:0] MUTE_LOAD = 8'(MUTE_SAMPLES - 1);

  estado_t                 state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic signed [width-1:0] baja_q, baja_d;
  logic signed [width-1:0] media_q, media_d;
  logic signed [width-1:0] alta_q, alta_d;
  logic [2:0]              valid_q, valid_d;

  logic                    ld;
  logic [7:0]              ld_val;
  logic                    dec;
  logic [7:0]              cnt;
  logic                    cnt_zero;

  logic                    fire;
  logic signed [width-1:0] dato;
  logic [2:0]              lane;

  mute_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .load_value (ld_val),
    .dec        (dec),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // Next state; sel only matters on a sample strobe.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ld      = 1'b0;
    ld_val  = MUTE_LOAD;
    dec     = 1'b0;
    fire    = 1'b0;
    dato    = '0;
    if (muestra_valid) begin
      if (sel != sel_q) begin
        sel_d = sel;
        ld    = 1'b1;
        if (sel == BANDA_NINGUNA) begin
          ld_val  = 8'd0;
          state_d = ST_RUN;
        end else begin
          // This strobe is already the first zero.
          fire    = 1'b1;
          state_d = (MUTE_LOAD == 8'd0) ? ST_RUN : ST_MUTE;
        end
      end else if (sel_q != BANDA_NINGUNA) begin
        fire = 1'b1;
        if (state_q == ST_MUTE) begin
          dec = 1'b1;
          if (cnt_zero || (cnt == 8'd1)) begin
            state_d = ST_RUN;
          end
        end else begin
          dato = muestra_in;
        end
      end
    end
  end

  assign lane = fire ? banda_onehot(sel_d) : 3'b000;

  // Outputs are rebuilt on every strobe, so unused lanes read 0.
  always_comb begin
    baja_d  = baja_q;
    media_d = media_q;
    alta_d  = alta_q;
    valid_d = lane;
    if (muestra_valid) begin
      baja_d  = lane[0] ? dato : '0;
      media_d = lane[1] ? dato : '0;
      alta_d  = lane[2] ? dato : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      sel_q   <= BANDA_NINGUNA;
      baja_q  <= '0;
      media_q <= '0;
      alta_q  <= '0;
      valid_q <= 3'b000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      baja_q  <= baja_d;
      media_q <= media_d;
      alta_q  <= alta_d;
      valid_q <= valid_d;
    end
  end

  assign banda_baja   = baja_q;
  assign banda_media  = media_q;
  assign banda_alta   = alta_q;
  assign valid_baja   = valid_q[0];
  assign valid_media  = valid_q[1];
  assign valid_alta   = valid_q[2];
  assign sel_activo   = sel_q;
  assign cambio_banda = (state_q == ST_MUTE);

endmodule

// File: tb/tb_demux_filtro.sv
// Directed bench for demux_filtro with a scoreboard of expected
// per-cycle outputs derived from a small behavioural band model.
module tb_demux_filtro;

  localparam int W = 22;
  localparam int MUTE = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic signed [W-1:0] muestra_in = '0;
  logic                muestra_valid = 1'b0;
  logic [1:0]          sel = 2'b00;
  logic signed [W-1:0] banda_baja, banda_media, banda_alta;
  logic                valid_baja, valid_media, valid_alta;
  logic [1:0]          sel_activo;
  logic                cambio_banda;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         strobe;
    logic [1:0] lane;
    logic [W-1:0] data;
    logic [1:0] act;
    bit         mute;
  } exp_t;

  exp_t q[$];

  logic [1:0] m_act = 2'b00;
  int         m_left = 0;

  always #5 clk = ~clk;

  demux_filtro #(.width(W), .MUTE_SAMPLES(MUTE)) dut (
    .clk           (clk),
    .reset         (reset),
    .muestra_in    (muestra_in),
    .muestra_valid (muestra_valid),
    .sel           (sel),
    .banda_baja    (banda_baja),
    .banda_media   (banda_media),
    .banda_alta    (banda_alta),
    .valid_baja    (valid_baja),
    .valid_media   (valid_media),
    .valid_alta    (valid_alta),
    .sel_activo    (sel_activo),
    .cambio_banda  (cambio_banda)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Zeros owed to the current band; the first is sent on the
  // switching strobe itself.
  function automatic exp_t model(input bit v, input logic [1:0] s,
                                 input logic [W-1:0] d);
    exp_t e;
    e.strobe = v;
    e.lane = 2'b00;
    e.data = '0;
    if (v) begin
      if (s != m_act) begin
        m_act = s;
        if (s == 2'b00) begin
          m_left = 0;
        end else begin
          m_left = MUTE - 1;
          e.lane = s;
        end
      end else if (m_act != 2'b00) begin
        e.lane = m_act;
        if (m_left > 0) begin
          m_left--;
        end else begin
          e.data = d;
        end
      end
    end
    e.act = m_act;
    e.mute = (m_left > 0);
    return e;
  endfunction

  task automatic step(input bit v, input logic [1:0] s,
                      input logic [W-1:0] d);
    exp_t e;
    logic [2:0] vexp;
    @(negedge clk);
    muestra_valid = v;
    sel = s;
    muestra_in = d;
    q.push_back(model(v, s, d));
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: empty queue");
    end else begin
      e = q.pop_front();
      vexp = (e.lane == 2'b00) ? 3'b000 : 3'(1 << (e.lane - 1));
      chk("valid", {29'd0, valid_alta, valid_media, valid_baja},
          {29'd0, vexp});
      chk("sel_activo", {30'd0, sel_activo}, {30'd0, e.act});
      chk("cambio_banda", {31'd0, cambio_banda}, {31'd0, e.mute});
      if (e.strobe) begin
        chk("banda_baja", {10'd0, banda_baja},
            {10'd0, (e.lane == 2'b01) ? e.data : {W{1'b0}}});
        chk("banda_media", {10'd0, banda_media},
            {10'd0, (e.lane == 2'b10) ? e.data : {W{1'b0}}});
        chk("banda_alta", {10'd0, banda_alta},
            {10'd0, (e.lane == 2'b11) ? e.data : {W{1'b0}}});
      end
    end
  endtask

  task automatic strobe(input logic [1:0] s, input logic [W-1:0] d);
    step(1'b1, s, d);
    step(1'b0, s, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_baja"}, {10'd0, banda_baja}, 32'd0);
    chk({tag, "_media"}, {10'd0, banda_media}, 32'd0);
    chk({tag, "_alta"}, {10'd0, banda_alta}, 32'd0);
    chk({tag, "_valid"}, {29'd0, valid_alta, valid_media, valid_baja}, 32'd0);
    chk({tag, "_sel"}, {30'd0, sel_activo}, 32'd0);
    chk({tag, "_cambio"}, {31'd0, cambio_banda}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: reset asserted mid-cycle while muting media
    strobe(2'b10, 22'd55);
    strobe(2'b10, 22'd56);
    @(negedge clk);
    muestra_in = W'($urandom);
    sel = 2'($urandom);
    muestra_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    muestra_valid = 1'b0;
    reset = 1'b0;
    m_act = 2'b00;
    m_left = 0;
    q.delete();

    // 2: 00 -> 01, samples 100..107
    for (int i = 0; i < 8; i++) strobe(2'b01, W'(100 + i));

    // 3: media, then alta after two muted strobes
    strobe(2'b10, 22'd200);
    strobe(2'b10, 22'd201);
    for (int i = 0; i < 6; i++) strobe(2'b11, W'(300 + i));

    // 4: settle on media, glitch sel between strobes
    for (int i = 0; i < 5; i++) strobe(2'b10, W'(400 + i));
    step(1'b0, 2'b11, 22'd0);
    step(1'b0, 2'b10, 22'd0);
    step(1'b0, 2'b11, 22'd0);
    step(1'b0, 2'b10, 22'd0);
    strobe(2'b10, 22'd777);

    // 5: extremes on baja, back-to-back strobes
    for (int i = 0; i < 4; i++) strobe(2'b01, 22'd1);
    step(1'b1, 2'b01, 22'h200000);
    step(1'b1, 2'b01, 22'h1FFFFF);
    step(1'b0, 2'b01, 22'd0);

    // 6: deselect from alta, then reselect
    for (int i = 0; i < 5; i++) strobe(2'b11, W'(500 + i));
    strobe(2'b00, 22'd600);
    strobe(2'b00, 22'd601);
    for (int i = 0; i < 6; i++) strobe(2'b11, W'(700 + i));

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
